wdt_apb_servicer: RTL and testbench

- APB3 requester that drives the watchdog timer's register slave from the opposite end of the bus.
- Converts single-word service commands into complete, correctly ordered APB write/read sequences: unlock, write ICR or LOAD, relock; or read VALUE/RIS.
- Lets firmware-less logic or a system monitor kick or reload the watchdog without hand-sequencing the lock protocol.

---
 rtl/wdt_apb_servicer_if.sv | 38 +++
 rtl/wdt_apb_servicer.sv | 177 +++++++++++++++++
 tb/tb_wdt_apb_servicer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_apb_servicer_if.sv
// Bundle of the command/response handshake and the APB3 requester bus for
// wdt_apb_servicer.
//   master : the servicer side. It drives the APB control, address and write data,
//            cmd_ready and the response signals.
//   slave  : the environment side. It drives the commands and the APB slave
//            responses.
interface wdt_apb_servicer_if #(
    parameter int ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       cmd_data;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/wdt_apb_servicer.sv
// APB3 requester that services a watchdog register slave.
// A single command expands into a correctly ordered APB sequence:
//   KICK       : W LOCK=LOCK_KEY, W ICR=1,        W LOCK=0
//   RELOAD     : W LOCK=LOCK_KEY, W LOAD=cmd_data, W LOCK=0
//   READ_VALUE : R VALUE
//   READ_RIS   : R RIS
// Ports:
//   pclk, presetn : clock, and an asynchronous active-low reset
//   bus           : command/response handshake plus the APB requester
//                   signals (master modport)
module wdt_apb_servicer #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] LOCK_KEY = 32'h1ACC_E551,
    parameter int          TIMEOUT  = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    wdt_apb_servicer_if.master bus
);
    localparam logic [ADDR_W-1:0] A_LOAD  = ADDR_W'(12'h000);
    localparam logic [ADDR_W-1:0] A_VALUE = ADDR_W'(12'h004);
    localparam logic [ADDR_W-1:0] A_ICR   = ADDR_W'(12'h00C);
    localparam logic [ADDR_W-1:0] A_RIS   = ADDR_W'(12'h010);
    localparam logic [ADDR_W-1:0] A_LOCK  = ADDR_W'(12'hC00);

    localparam int              WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    // S_ABORT is the single idle-bus cycle that follows a timed-out step.
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ABORT, S_RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_op, r_step, w_step_nxt;
    logic [31:0]       r_data, r_rdata;
    logic              r_err, w_err_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [31:0]       r_pwdata;

    logic              w_load, w_is_rd, w_relock_pending, w_timeout;
    logic [1:0]        w_op;
    logic [31:0]       w_ld;
    logic [ADDR_W-1:0] w_paddr;
    logic [31:0]       w_pwdata;
    logic              w_pwrite;

    assign w_is_rd          = r_op[1];
    // A failing write step before the relock still jumps to the relock step.
    assign w_relock_pending = !w_is_rd && (r_step != 2'd2);
    // This fires on the TIMEOUT-th consecutive wait cycle of a step.
    assign w_timeout        = (TIMEOUT > 0) && !bus.pready && (r_wait == WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_err_nxt   = r_err;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = S_SETUP;
                    w_step_nxt  = 2'd0;
                    w_err_nxt   = 1'b0;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    if (bus.pslverr) w_err_nxt = 1'b1;
                    if (bus.pslverr && w_relock_pending) begin
                        w_step_nxt  = 2'd2;
                        w_state_nxt = S_SETUP;
                        w_load      = 1'b1;
                    end else if (w_is_rd || r_step == 2'd2) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_step_nxt  = r_step + 2'd1;
                        w_state_nxt = S_SETUP;
                        w_load      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                if (w_relock_pending) begin
                    w_step_nxt  = 2'd2;
                    w_state_nxt = S_SETUP;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Decode the step about to be presented. In IDLE, the not-yet-latched
    // command fields are used, so that the first SETUP already shows the
    // right address.
    always_comb begin
        w_op     = (r_state == S_IDLE) ? bus.cmd_op   : r_op;
        w_ld     = (r_state == S_IDLE) ? bus.cmd_data : r_data;
        w_paddr  = A_LOCK;
        w_pwdata = '0;
        w_pwrite = 1'b1;
        if (w_op[1]) begin
            w_pwrite = 1'b0;
            w_paddr  = w_op[0] ? A_RIS : A_VALUE;
        end else begin
            case (w_step_nxt)
                2'd0: begin
                    w_paddr  = A_LOCK;
                    w_pwdata = LOCK_KEY;
                end
                2'd1: begin
                    w_paddr  = w_op[0] ? A_LOAD : A_ICR;
                    w_pwdata = w_op[0] ? w_ld   : 32'h1;
                end
                default: begin
                    w_paddr  = A_LOCK;
                    w_pwdata = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_step   <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_wait   <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_err   <= w_err_nxt;
            if (r_state == S_IDLE && bus.cmd_valid) begin
                r_op    <= bus.cmd_op;
                r_data  <= bus.cmd_data;
                r_rdata <= '0;
            end
            if (w_load) begin
                r_paddr  <= w_paddr;
                r_pwdata <= w_pwdata;
                r_pwrite <= w_pwrite;
            end
            if (r_state == S_SETUP)
                r_wait <= '0;
            else if (r_state == S_ACCESS && !bus.pready && TIMEOUT > 0)
                r_wait <= r_wait + 1'b1;
            if (r_state == S_ACCESS && bus.pready && w_is_rd)
                r_rdata <= bus.prdata;
        end
    end

    assign bus.psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign bus.penable   = (r_state == S_ACCESS);
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_err   = (r_state == S_RESP) && r_err;
    assign bus.rsp_data  = (r_state == S_RESP && !r_err) ? r_rdata : '0;
endmodule

// File: tb/tb_wdt_apb_servicer.sv
module tb_wdt_apb_servicer;
    localparam int          TO  = 16;
    localparam logic [31:0] KEY = 32'h1ACC_E551;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    wdt_apb_servicer_if #(.ADDR_W(12)) bus ();

    wdt_apb_servicer #(.ADDR_W(12), .LOCK_KEY(KEY), .TIMEOUT(TO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Per-transfer slave behaviour for the current command: the number of
    // wait states, the pslverr flag and the read data. A wait count >= TO
    // never completes.
    int          w  [3];
    bit          e  [3];
    logic [31:0] rd [3];
    int          k;
    bit          stray_en;

    // The transfers observed on the bus, recorded at SETUP.
    logic [11:0] oa [$];
    bit          ow [$];
    logic [31:0] od [$];

    // APB slave model, driven on the falling edge.
    initial begin
        int          cnt;
        int          cur;
        logic [11:0] sa;
        logic [31:0] sd;
        bit          sw;
        cnt = 0; cur = 0; sa = '0; sd = '0; sw = 1'b0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                bus.pready = 1'b0; bus.pslverr = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                sa = bus.paddr; sd = bus.pwdata; sw = bus.pwrite;
                cur = (k < 3) ? k : 2;
                oa.push_back(sa); ow.push_back(sw); od.push_back(sw ? sd : 32'h0);
                k++; cnt = 0;
                bus.pready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.pslverr = 1'b0;
            end else if (bus.psel && bus.penable) begin
                chk("paddr_stable", {20'h0, bus.paddr}, {20'h0, sa});
                chk("pwdata_stable", bus.pwdata, sd);
                chk("pwrite_stable", {31'h0, bus.pwrite}, {31'h0, sw});
                if (cnt >= w[cur]) begin
                    bus.pready = 1'b1; bus.pslverr = e[cur]; bus.prdata = rd[cur];
                end else begin
                    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = $urandom;
                    cnt++;
                end
            end else begin
                // Stray pready outside a transfer must be ignored.
                bus.pready  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.pslverr = 1'b0;
            end
        end
    end

    // Reference: walk the command's step list under the slave's planned
    // behaviour, and produce the expected transfers, the error, the data and the cycle at which rsp_valid appears.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] data, input bit junk);
        logic [11:0] ea [$];
        bit          ew [$];
        logic [31:0] ed [$];
        int          idx, j, lat, n;
        bit          err, bad, done;
        logic [31:0] exp_rd;
        idx = 0; j = 0; lat = 0; err = 1'b0; done = 1'b0;
        while (!done) begin
            if (op[1]) begin
                ea.push_back(op[0] ? 12'h010 : 12'h004); ew.push_back(1'b0); ed.push_back(32'h0);
            end else if (idx == 0) begin
                ea.push_back(12'hC00); ew.push_back(1'b1); ed.push_back(KEY);
            end else if (idx == 1) begin
                ea.push_back(op[0] ? 12'h000 : 12'h00C); ew.push_back(1'b1);
                ed.push_back(op[0] ? data : 32'h1);
            end else begin
                ea.push_back(12'hC00); ew.push_back(1'b1); ed.push_back(32'h0);
            end
            bad = (w[j] >= TO) || e[j];
            lat += (w[j] >= TO) ? TO + 2 : w[j] + 2;
            if (bad) err = 1'b1;
            if (op[1]) done = 1'b1;
            else if (bad && idx < 2) idx = 2;
            else if (idx == 2) done = 1'b1;
            else idx++;
            j++;
        end
        exp_rd = (op[1] && !err) ? rd[0] : 32'h0;

        @(negedge pclk);
        k = 0; oa.delete(); ow.delete(); od.delete();
        chk("idle_ready", {31'h0, bus.cmd_ready}, 32'h1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
            if (n == 1) begin
                chk("busy", {31'h0, bus.busy}, 32'h1);
                chk("ready_low", {31'h0, bus.cmd_ready}, 32'h0);
                // A held command while busy must not be taken.
                bus.cmd_valid = junk;
                bus.cmd_op    = 2'($urandom);
                bus.cmd_data  = $urandom;
            end
        end while (!bus.rsp_valid && n < 400);
        bus.cmd_valid = 1'b0;
        chk("rsp_cycle", n, lat + 1);
        chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, err});
        chk("rsp_data", bus.rsp_data, exp_rd);
        chk("n_xfers", oa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
            chk("xfer_addr", {20'h0, oa[i]}, {20'h0, ea[i]});
            chk("xfer_wr", {31'h0, ow[i]}, {31'h0, ew[i]});
            chk("xfer_wdata", od[i], ed[i]);
        end
        @(negedge pclk);
        chk("rsp_pulse", {31'h0, bus.rsp_valid}, 32'h0);
        chk("ready_back", {31'h0, bus.cmd_ready}, 32'h1);
    endtask

    task automatic plan(input int w0, input int w1, input int w2,
                        input bit e0, input bit e1, input bit e2);
        w[0] = w0; w[1] = w1; w[2] = w2;
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int i = 0; i < 3; i++) rd[i] = $urandom;
    endtask

    initial begin
        int n;
        bit seen;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_data = '0;
        k = 0; stray_en = 1'b0;
        plan(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge pclk);
        chk("rst_psel", {31'h0, bus.psel}, 32'h0);
        chk("rst_penable", {31'h0, bus.penable}, 32'h0);
        chk("rst_pwrite", {31'h0, bus.pwrite}, 32'h0);
        chk("rst_paddr", {20'h0, bus.paddr}, 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_rsp", {29'h0, bus.rsp_valid, bus.rsp_err, bus.busy}, 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
        presetn = 1'b1;

        // Directed scenarios
        plan(0, 0, 0, 0, 0, 0);       run_cmd(2'd0, 32'h0, 1'b0);          // KICK, zero wait
        plan(2, 2, 2, 0, 0, 0);       run_cmd(2'd1, 32'h0000_0100, 1'b0);  // RELOAD, 2 waits
        plan(0, 0, 0, 0, 0, 0); rd[0] = 32'h1234_5678;
        run_cmd(2'd2, 32'h0, 1'b0);                                       // READ_VALUE
        plan(0, 0, 0, 0, 1, 0);       run_cmd(2'd0, 32'h0, 1'b0);          // slverr on ICR
        stray_en = 1'b1;
        plan(TO + 4, 0, 0, 0, 0, 0);  run_cmd(2'd3, 32'h0, 1'b0);          // RIS timeout
        plan(TO + 4, 0, 0, 0, 0, 0);  run_cmd(2'd1, 32'h55, 1'b1);         // unlock timeout
        stray_en = 1'b0;

        // Reset during the second ACCESS of a KICK
        plan(0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        k = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_data = '0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.psel && bus.penable && k == 2) && n < 50) begin
            @(negedge pclk); n++;
        end
        chk("reach_2nd_access", {31'h0, 1'(n < 50)}, 32'h1);
        presetn = 1'b0;
        #1;
        chk("arst_psel", {30'h0, bus.psel, bus.penable}, 32'h0);
        chk("arst_busy", {31'h0, bus.busy}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        presetn = 1'b1;
        repeat (4) begin
            @(negedge pclk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("arst_no_rsp", {31'h0, seen}, 32'h0);
        chk("arst_ready", {31'h0, bus.cmd_ready}, 32'h1);
        plan(0, 0, 0, 0, 0, 0);       run_cmd(2'd0, 32'h0, 1'b0);

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            stray_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                w[i]  = ($urandom_range(0, 7) == 0) ? TO + 4 : int'($urandom_range(0, 3));
                e[i]  = ($urandom_range(0, 5) == 0);
                rd[i] = $urandom;
            end
            run_cmd(2'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
